// File: rtl/rock_spawner.sv
// Rock spawner: every SPAWN_INTERVAL frames, launches a rock into the lowest free slot from a random screen edge.
// Build option ROCK_SPAWN_RAMP_EN: each confirmed launch shortens the interval by 8 frames (floor 30).
//
// state   | meaning
// IDLE    | frame counter runs down while enable is high
// SEARCH  | pick lowest free slot, capture launch parameters
// ISSUE   | one-cycle start strobe to the chosen slot
// CONFIRM | slot must have gone busy, else spawnFail
module rock_spawner #(
    parameter int NUM_ROCKS      = 8,
    parameter int SPAWN_INTERVAL = 120
) (
    input  logic                 clk60hz,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [NUM_ROCKS-1:0] inUse,
    output logic [NUM_ROCKS-1:0] start,
    output logic [9:0]           initialX,
    output logic [9:0]           initialY,
    output logic [2:0]           dirX,
    output logic [2:0]           dirY,
    output logic [7:0]           spawnCount,
    output logic                 spawnFail
);

    localparam int          SW        = $clog2(NUM_ROCKS);
    localparam logic [9:0]  INTERVAL  = 10'(SPAWN_INTERVAL);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, SEARCH, ISSUE, CONFIRM} state_t;

    state_t               state_q;
    logic [9:0]           frame_cnt_q;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 slot_found_d;
    logic                 seen_q;
    logic [NUM_ROCKS-1:0] start_q;
    logic [9:0]           x_q, y_q, x_d, y_d;
    logic [2:0]           dx_q, dy_q, dx_d, dy_d;
    logic [7:0]           count_q;
    logic                 fail_q;
    logic [9:0]           reload_w, reload_next_w;
    logic [9:0]           along_w, across_w;
    logic [1:0]           mag_x_in_w, mag_y_in_w;

`ifdef ROCK_SPAWN_RAMP_EN
    logic [9:0] reload_q;
    assign reload_w      = reload_q;
    assign reload_next_w = (reload_q >= 10'd38) ? reload_q - 10'd8 :
                           ((reload_q > 10'd30) ? 10'd30 : reload_q);
`else
    assign reload_w      = INTERVAL;
    assign reload_next_w = INTERVAL;
`endif

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting; never reaches zero from a nonzero seed
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_comb begin
        slot_d       = '0;
        slot_found_d = 1'b0;
        for (int i = NUM_ROCKS - 1; i >= 0; i--) begin
            if (!inUse[i]) begin
                slot_d       = SW'(i);
                slot_found_d = 1'b1;
            end
        end
    end

    always_comb begin
        along_w    = (lfsr_q[15:7] >= 9'd480) ? {1'b0, lfsr_q[15:7]} - 10'd32 : {1'b0, lfsr_q[15:7]};
        across_w   = {1'b0, lfsr_q[15:7]} + 10'd64;
        mag_x_in_w = (lfsr_q[3:2] == 2'b00) ? 2'b01 : lfsr_q[3:2];
        mag_y_in_w = (lfsr_q[5:4] == 2'b00) ? 2'b01 : lfsr_q[5:4];
        x_d  = '0;
        y_d  = '0;
        dx_d = '0;
        dy_d = '0;
        case (lfsr_q[1:0])
            2'd0: begin
                x_d  = 10'd0;
                y_d  = along_w;
                dx_d = {1'b0, mag_x_in_w};
                dy_d = {lfsr_q[6], lfsr_q[5:4]};
            end
            2'd1: begin
                x_d  = 10'd639;
                y_d  = along_w;
                dx_d = {1'b1, mag_x_in_w};
                dy_d = {lfsr_q[6], lfsr_q[5:4]};
            end
            2'd2: begin
                x_d  = across_w;
                y_d  = 10'd0;
                dx_d = {lfsr_q[6], lfsr_q[3:2]};
                dy_d = {1'b0, mag_y_in_w};
            end
            default: begin
                x_d  = across_w;
                y_d  = 10'd479;
                dx_d = {lfsr_q[6], lfsr_q[3:2]};
                dy_d = {1'b1, mag_y_in_w};
            end
        endcase
    end

    always_ff @(posedge clk60hz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            frame_cnt_q <= INTERVAL;
            lfsr_q      <= LFSR_SEED;
            slot_q      <= '0;
            seen_q      <= 1'b0;
            start_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            count_q     <= '0;
            fail_q      <= 1'b0;
`ifdef ROCK_SPAWN_RAMP_EN
            reload_q    <= INTERVAL;
`endif
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= '0;
            fail_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (frame_cnt_q <= 10'd1) begin
                            state_q     <= SEARCH;
                            frame_cnt_q <= reload_w;
                        end else begin
                            frame_cnt_q <= frame_cnt_q - 10'd1;
                        end
                    end
                end
                SEARCH: begin
                    if (slot_found_d) begin
                        slot_q  <= slot_d;
                        start_q <= NUM_ROCKS'(1) << slot_d;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        dx_q    <= dx_d;
                        dy_q    <= dy_d;
                        state_q <= ISSUE;
                    end else begin
                        // every slot busy: retry on the very next frame
                        frame_cnt_q <= 10'd1;
                        state_q     <= IDLE;
                    end
                end
                ISSUE: begin
                    seen_q  <= inUse[slot_q];
                    state_q <= CONFIRM;
                end
                CONFIRM: begin
                    if (seen_q || inUse[slot_q]) begin
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                        frame_cnt_q <= reload_next_w;
`ifdef ROCK_SPAWN_RAMP_EN
                        reload_q    <= reload_next_w;
`endif
                    end else begin
                        fail_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start      = start_q;
    assign initialX   = x_q;
    assign initialY   = y_q;
    assign dirX       = dx_q;
    assign dirY       = dy_q;
    assign spawnCount = count_q;
    assign spawnFail  = fail_q;

endmodule

// File: tb/tb_rock_spawner.sv
// Bench for rock_spawner: directed timing checks on a 120-frame instance plus a
// randomized 1000-launch run on a 1-frame instance against a behavioural launch model.
`timescale 1ns/1ps
module tb_rock_spawner;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    always #5 clk = ~clk;

    logic       en_m, en_f;
    logic [7:0] use_m, use_f, start_m, start_f, cnt_m, cnt_f;
    logic [9:0] x_m, y_m, x_f, y_f;
    logic [2:0] dx_m, dy_m, dx_f, dy_f;
    logic       fail_m, fail_f;

    rock_spawner #(.NUM_ROCKS(8), .SPAWN_INTERVAL(120)) u_dut (
        .clk60hz(clk), .resetn(resetn), .enable(en_m), .inUse(use_m), .start(start_m),
        .initialX(x_m), .initialY(y_m), .dirX(dx_m), .dirY(dy_m),
        .spawnCount(cnt_m), .spawnFail(fail_m)
    );

    rock_spawner #(.NUM_ROCKS(8), .SPAWN_INTERVAL(1)) u_fast (
        .clk60hz(clk), .resetn(resetn), .enable(en_f), .inUse(use_f), .start(start_f),
        .initialX(x_f), .initialY(y_f), .dirX(dx_f), .dirY(dy_f),
        .spawnCount(cnt_f), .spawnFail(fail_f)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int v, b;
        v = int'(l);
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    // Model LFSR; m_prev is the value the DUT held during the cycle before the last edge
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    function automatic void exp_launch(input logic [15:0] l, output int ex, output int ey,
                                       output int edx, output int edy);
        int c, e, mx, my, s, along, inx, iny;
        c     = int'(l[15:7]);
        e     = int'(l[1:0]);
        mx    = int'(l[3:2]);
        my    = int'(l[5:4]);
        s     = int'(l[6]);
        along = (c >= 480) ? c - 32 : c;
        inx   = (mx == 0) ? 1 : mx;
        iny   = (my == 0) ? 1 : my;
        case (e)
            0:       begin ex = 0;      ey = along; edx = inx;        edy = s * 4 + my; end
            1:       begin ex = 639;    ey = along; edx = 4 + inx;    edy = s * 4 + my; end
            2:       begin ex = c + 64; ey = 0;     edx = s * 4 + mx; edy = iny;        end
            default: begin ex = c + 64; ey = 479;   edx = s * 4 + mx; edy = 4 + iny;    end
        endcase
    endfunction

    task automatic check_params(input string who, input logic [9:0] x, input logic [9:0] y,
                                input logic [2:0] dx, input logic [2:0] dy);
        int ex, ey, edx, edy, e;
        exp_launch(m_prev, ex, ey, edx, edy);
        e = int'(m_prev[1:0]);
        chk({who, "_x"}, int'(x), ex);
        chk({who, "_y"}, int'(y), ey);
        chk({who, "_dirx"}, int'(dx), edx);
        chk({who, "_diry"}, int'(dy), edy);
        chk({who, "_x_range"}, int'(x <= 10'd639), 1);
        chk({who, "_y_range"}, int'(y <= 10'd479), 1);
        if (e < 2) begin
            chk({who, "_in_mag"}, int'(dx[1:0] != 2'b00), 1);
            chk({who, "_in_sign"}, int'(dx[2]), int'(e == 1));
        end else begin
            chk({who, "_in_mag"}, int'(dy[1:0] != 2'b00), 1);
            chk({who, "_in_sign"}, int'(dy[2]), int'(e == 3));
        end
    endtask

    task automatic wait_start_m(input string tag, input int max);
        int n;
        n = 0;
        while (start_m == 8'h00 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(start_m != 8'h00), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, any, launches, last, clr, r, low, mode, model_cnt;
        logic [7:0]  pat, exp_oh;
        logic [25:0] held;

        en_m = 1'b1; use_m = '0; en_f = 1'b0; use_f = '0; resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", int'(start_m), 0);
        chk("rst_x", int'(x_m), 0);
        chk("rst_y", int'(y_m), 0);
        chk("rst_dir", int'({dx_m, dy_m}), 0);
        chk("rst_count", int'(cnt_m), 0);
        chk("rst_fail", int'(fail_m), 0);

        // First launch after reset; nobody answers, so it must fail
        resetn = 1'b1;
        n = 0;
        while (start_m == 8'h00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("first_start_edge", n, 121);
        chk("first_start_val", int'(start_m), 8'h01);
        check_params("m", x_m, y_m, dx_m, dy_m);
        held = {x_m, y_m, dx_m, dy_m};
        @(negedge clk);
        chk("start_width", int'(start_m), 0);
        chk("param_hold", int'({x_m, y_m, dx_m, dy_m}), int'(held));
        chk("fail_early", int'(fail_m), 0);
        @(negedge clk);
        chk("fail_pulse", int'(fail_m), 1);
        chk("fail_count", int'(cnt_m), 0);
        @(negedge clk);
        chk("fail_width", int'(fail_m), 0);

        // Only slot 3 free; enable dropped mid-attempt must not abort it
        use_m = 8'b1111_0111;
        wait_start_m("b_timeout", 250);
        chk("b_slot3", int'(start_m), 8'h08);
        use_m = use_m | start_m;
        en_m  = 1'b0;
        @(negedge clk);
        chk("b_count_pre", int'(cnt_m), 0);
        @(negedge clk);
        chk("b_count_post", int'(cnt_m), 1);
        chk("b_nofail", int'(fail_m), 0);
        any = 0;
        repeat (150) begin
            @(negedge clk);
            if (start_m != 8'h00) any++;
        end
        chk("hold_no_start", any, 0);

        // All slots busy, then slot 7 frees up
        use_m = 8'hFF;
        en_m  = 1'b1;
        any = 0;
        repeat (300) begin
            @(negedge clk);
            if (start_m != 8'h00) any++;
        end
        chk("full_no_start", any, 0);
        use_m = 8'h7F;
        n = 0;
        while (start_m == 8'h00 && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("full_release_start", int'(start_m), 8'h80);
        use_m = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk("c_count", int'(cnt_m), 2);

        // Reset while the strobe is high
        use_m = '0;
        wait_start_m("rst_issue_timeout", 200);
        #2 resetn = 1'b0;
        #1;
        chk("rst_issue_start", int'(start_m), 0);
        chk("rst_issue_xy", int'({x_m, y_m}), 0);
        chk("rst_issue_dir", int'({dx_m, dy_m}), 0);
        chk("rst_issue_count", int'(cnt_m), 0);
        @(negedge clk);
        resetn = 1'b1;

        // 15 confirmed launches: start-to-start spacing minus attempt overhead is the interval
        r = 120; launches = 0; n = 0; last = 0; clr = 0;
        while (launches < 15 && n < 4000) begin
            @(negedge clk);
            n++;
            if (start_m != 8'h00) begin
                chk("interval", (launches == 0) ? n - 1 : n - last - 3, r);
`ifdef ROCK_SPAWN_RAMP_EN
                r = (r - 8 < 30) ? 30 : r - 8;
`endif
                last = n;
                launches++;
                use_m = start_m;
                clr = 3;
            end else if (clr > 0) begin
                clr--;
                if (clr == 0) use_m = '0;
            end
        end
        chk("interval_launches", launches, 15);
        @(negedge clk);
        @(negedge clk);
        chk("interval_count", int'(cnt_m), 15);
        en_m = 1'b0;

        // Randomized launches on the fast instance
        model_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            pat  = 8'($urandom_range(0, 255));
            mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                use_f = 8'hFF;
                en_f  = 1'b1;
                any = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (start_f != 8'h00) any++;
                end
                chk("f_busy_no_start", any, 0);
                pat = 8'hFF;
                pat[$urandom_range(0, 7)] = 1'b0;
            end else if (pat == 8'hFF) begin
                pat = 8'hFE;
            end
            low = 0;
            while (low < 8 && pat[low]) low++;
            exp_oh = 8'(1) << low;
            use_f = pat;
            en_f  = 1'b1;
            n = 0;
            while (start_f == 8'h00 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("f_start", int'(start_f), int'(exp_oh));
            check_params("f", x_f, y_f, dx_f, dy_f);
            held = {x_f, y_f, dx_f, dy_f};
            en_f = 1'b0;
            if (mode == 1) use_f = use_f | exp_oh;
            @(negedge clk);
            chk("f_start_drop", int'(start_f), 0);
            chk("f_param_hold", int'({x_f, y_f, dx_f, dy_f}), int'(held));
            if (mode == 2) use_f = use_f | exp_oh;
            @(negedge clk);
            if (mode != 0 && model_cnt < 255) model_cnt++;
            chk("f_fail", int'(fail_f), int'(mode == 0));
            chk("f_count", int'(cnt_f), model_cnt);
            @(negedge clk);
            chk("f_fail_width", int'(fail_f), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
